// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with NRD combinational read
// ports, two prioritised write ports, write-to-read bypass, optional
// hardwired-zero register 0 and a one-register-per-cycle bulk-clear engine.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    input  logic [1:0]            wr_en,
    input  logic [2*AW-1:0]       wr_addr,
    input  logic [2*XLEN-1:0]     wr_data,
    input  logic                  clr_req,
    output logic                  clr_busy
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [0:0]            r_state;
    logic [AW-1:0]         r_idx;
    logic [NREGS*XLEN-1:0] w_regs_flat;
    logic [NRD*XLEN-1:0]   w_rd_data;

    logic                  w_wr_ok;
    logic                  w_we0;
    logic                  w_we1;
    logic [AW-1:0]         w_wa0;
    logic [AW-1:0]         w_wa1;
    logic [XLEN-1:0]       w_wd0;
    logic [XLEN-1:0]       w_wd1;

    // Writes only land in IDLE, and lose to a clear request sampled on the
    // same edge; the same qualified enables gate the bypass path so a
    // dropped write is never forwarded.
    assign w_wr_ok = (r_state == S_IDLE) && !clr_req;
    assign w_we0   = wr_en[0] && w_wr_ok;
    assign w_we1   = wr_en[1] && w_wr_ok;
    assign w_wa0   = wr_addr[0 +: AW];
    assign w_wa1   = wr_addr[AW +: AW];
    assign w_wd0   = wr_data[0 +: XLEN];
    assign w_wd1   = wr_data[XLEN +: XLEN];

    // Clear-engine FSM: walks r_idx from 0 to NREGS-1, one register per edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= {AW{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clr_req) begin
                        r_state <= S_CLEAR;
                        r_idx   <= {AW{1'b0}};
                    end else begin
                        r_state <= S_IDLE;
                        r_idx   <= r_idx;
                    end
                end
                S_CLEAR: begin
                    if (r_idx == AW'(NREGS - 1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_CLEAR;
                    end
                    r_idx <= r_idx + AW'(1);
                end
                default: begin
                    r_state <= S_IDLE;
                    r_idx   <= {AW{1'b0}};
                end
            endcase
        end
    end

    // Storage: one flop word per register, exposed as a flat vector for the
    // read muxes. Port 1 is tested first so it wins a same-address collision.
    for (genvar g = 0; g < NREGS; g++) begin : g_reg
        localparam logic [AW-1:0] L_ADDR     = AW'(g);
        localparam bit            L_WRITABLE = !((ZERO_REG != 0) && (g == 0));

        logic [XLEN-1:0] r_q;

        // Register update: clear engine first, then port 1, then port 0.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_q <= {XLEN{1'b0}};
            end else if ((r_state == S_CLEAR) && (r_idx == L_ADDR)) begin
                r_q <= {XLEN{1'b0}};
            end else if (L_WRITABLE && w_we1 && (w_wa1 == L_ADDR)) begin
                r_q <= w_wd1;
            end else if (L_WRITABLE && w_we0 && (w_wa0 == L_ADDR)) begin
                r_q <= w_wd0;
            end else begin
                r_q <= r_q;
            end
        end

        assign w_regs_flat[g*XLEN +: XLEN] = r_q;
    end

    // Read ports: clear blanking, zero register, port-1 bypass, port-0
    // bypass, then the stored array, in that priority order.
    always_comb begin
        w_rd_data = {(NRD*XLEN){1'b0}};
        for (int k = 0; k < NRD; k++) begin
            if (r_state == S_CLEAR) begin
                w_rd_data[k*XLEN +: XLEN] = {XLEN{1'b0}};
            end else if ((ZERO_REG != 0) && (rd_addr[k*AW +: AW] == {AW{1'b0}})) begin
                w_rd_data[k*XLEN +: XLEN] = {XLEN{1'b0}};
            end else if (w_we1 && (w_wa1 == rd_addr[k*AW +: AW])) begin
                w_rd_data[k*XLEN +: XLEN] = w_wd1;
            end else if (w_we0 && (w_wa0 == rd_addr[k*AW +: AW])) begin
                w_rd_data[k*XLEN +: XLEN] = w_wd0;
            end else begin
                w_rd_data[k*XLEN +: XLEN] = w_regs_flat[rd_addr[k*AW +: AW]*XLEN +: XLEN];
            end
        end
    end

    assign rd_data  = w_rd_data;
    // The state flop itself is the busy flag, so clr_busy comes straight
    // from a register.
    assign clr_busy = r_state[0];

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scoreboard bench for regfile_mp. Two instances share
// all stimulus: one with ZERO_REG=1 (main checks) and one with ZERO_REG=0
// (register-0 behaviour only).
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data_a;
    logic [63:0] rd_data_b;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        clr_req;
    logic        busy_a;
    logic        busy_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [32];
    logic [31:0] x0_b;

    typedef struct {
        string       tag;
        int          dut;
        int          port;
        logic [31:0] exp;
    } sb_t;
    sb_t sbq[$];

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1)) u_dut_zr1 (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_req(clr_req), .clr_busy(busy_a)
    );

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(0)) u_dut_zr0 (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_req(clr_req), .clr_busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a read address and push its expected value to the scoreboard.
    task automatic rd(input int dut, input int port, input int addr,
                      input logic [31:0] exp, input string tag);
        sb_t e;
        rd_addr[port*5 +: 5] = 5'(addr);
        e.tag  = tag;
        e.dut  = dut;
        e.port = port;
        e.exp  = exp;
        sbq.push_back(e);
    endtask

    // Let the combinational read settle, then pop and compare every entry.
    task automatic drain();
        sb_t         e;
        logic [63:0] v;
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            v = (e.dut == 0) ? rd_data_a : rd_data_b;
            chk(e.tag, v[e.port*32 +: 32], e.exp);
        end
    endtask

    task automatic wr(input int port, input int addr, input logic [31:0] data);
        wr_en[port]            = 1'b1;
        wr_addr[port*5 +: 5]   = 5'(addr);
        wr_data[port*32 +: 32] = data;
    endtask

    // Reference update for an accepted write (x0 is hardwired in instance A).
    task automatic commit(input int addr, input logic [31:0] data);
        if (addr == 0) x0_b = data;
        else           mdl[addr] = data;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        x0_b = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        rst = 1'b1; rd_addr = 10'h0; wr_en = 2'b00; wr_addr = 10'h0;
        wr_data = 64'h0; clr_req = 1'b0;
        model_clear();

        // Reset state
        repeat (2) @(negedge clk);
        chk("busy_in_reset", {31'b0, busy_a}, 32'd0);
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            rd(0, 0, a, 32'h0, "reset_rd_p0");
            rd(0, 1, 31 - a, 32'h0, "reset_rd_p1");
            drain();
        end

        // Basic write then read next cycle
        @(negedge clk); wr(0, 5, 32'hDEADBEEF);
        @(negedge clk); wr_en = 2'b00; commit(5, 32'hDEADBEEF);
        rd(0, 0, 5, mdl[5], "x5_readback");
        drain();

        // Same-cycle bypass from port 0
        @(negedge clk); wr(0, 7, 32'h1234);
        rd(0, 0, 7, 32'h1234, "bypass_p0");
        rd(0, 1, 5, mdl[5], "no_bypass_other_addr");
        drain();
        @(negedge clk); wr_en = 2'b00; commit(7, 32'h1234);
        rd(0, 0, 7, mdl[7], "x7_stored_p0");
        rd(0, 1, 7, mdl[7], "x7_stored_p1");
        drain();

        // Dual-write collision: port 1 wins
        @(negedge clk); wr(0, 9, 32'hAAAA); wr(1, 9, 32'h5555);
        rd(0, 0, 9, 32'h5555, "collision_bypass");
        drain();
        @(negedge clk); wr_en = 2'b00; commit(9, 32'h5555);
        rd(0, 1, 9, mdl[9], "collision_stored");
        drain();

        // Two writes to distinct addresses, each bypassed on its own port
        @(negedge clk); wr(0, 10, 32'h1010); wr(1, 11, 32'h1111);
        rd(0, 0, 10, 32'h1010, "dual_bypass_p0");
        rd(0, 1, 11, 32'h1111, "dual_bypass_p1");
        drain();
        @(negedge clk); wr_en = 2'b00; commit(10, 32'h1010); commit(11, 32'h1111);
        rd(0, 0, 11, mdl[11], "dual_stored_x11");
        rd(0, 1, 10, mdl[10], "dual_stored_x10");
        drain();

        // Register 0 with and without the hardwired zero
        @(negedge clk); wr(0, 0, 32'hFFFFFFFF);
        rd(0, 0, 0, 32'h0, "x0_zr1_bypass");
        rd(1, 1, 0, 32'hFFFFFFFF, "x0_zr0_bypass");
        drain();
        @(negedge clk); wr_en = 2'b00; commit(0, 32'hFFFFFFFF);
        rd(0, 0, 0, 32'h0, "x0_zr1_stored");
        rd(1, 1, 0, x0_b, "x0_zr0_stored");
        drain();

        // Fill every register with a nonzero value
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            wr(0, i, 32'hA5A50000 | 32'(i));
            wr(1, i + 16, 32'h5A5A0000 | 32'(i + 16));
            commit(i, 32'hA5A50000 | 32'(i));
            commit(i + 16, 32'h5A5A0000 | 32'(i + 16));
        end
        @(negedge clk); wr_en = 2'b00;
        rd(0, 0, 20, mdl[20], "fill_x20");
        rd(1, 1, 0, x0_b, "fill_x0_zr0");
        drain();

        // Clear request: the same-cycle write is dropped and not bypassed
        @(negedge clk); clr_req = 1'b1; wr(0, 3, 32'h99);
        rd(0, 0, 3, mdl[3], "clr_req_no_bypass");
        drain();
        chk("busy_before_clear", {31'b0, busy_a}, 32'd0);
        @(negedge clk); clr_req = 1'b0; wr_en = 2'b00;

        // Busy window: reads blank, writes dropped, second request ignored
        busy_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            if (busy_a !== 1'b1) break;
            busy_cnt++;
            rd(0, 0, c % 32, 32'h0, "read_during_clear");
            wr(0, c % 32, 32'hBAD00000 | 32'(c));
            wr(1, (c + 7) % 32, 32'hBAD10000 | 32'(c));
            clr_req = (c == 5);
            drain();
            @(negedge clk);
        end
        wr_en = 2'b00; clr_req = 1'b0;
        chk("busy_cycles", 32'(busy_cnt), 32'd32);
        chk("busy_b_after_clear", {31'b0, busy_b}, 32'd0);
        model_clear();
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            rd(0, 0, a, mdl[a], "after_clear_p0");
            rd(0, 1, 31 - a, mdl[31 - a], "after_clear_p1");
            drain();
        end
        @(negedge clk);
        rd(1, 0, 0, x0_b, "after_clear_x0_zr0");
        drain();

        // Write accepted again once busy has fallen
        @(negedge clk); wr(0, 3, 32'h33); wr(1, 20, 32'h2020);
        @(negedge clk); wr_en = 2'b00; commit(3, 32'h33); commit(20, 32'h2020);
        rd(0, 0, 3, mdl[3], "post_clear_write_x3");
        rd(0, 1, 20, mdl[20], "post_clear_write_x20");
        drain();

        // Asynchronous reset in the middle of a clear sequence
        @(negedge clk); clr_req = 1'b1;
        @(negedge clk); clr_req = 1'b0;
        chk("busy_started", {31'b0, busy_a}, 32'd1);
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("busy_after_async_rst", {31'b0, busy_a}, 32'd0);
        model_clear();
        rd(0, 0, 20, 32'h0, "rd_x20_in_rst");
        rd(1, 1, 3, 32'h0, "rd_x3_in_rst_zr0");
        drain();
        @(negedge clk); rst = 1'b0; wr(0, 3, 32'h77);
        @(negedge clk); wr_en = 2'b00; commit(3, 32'h77);
        rd(0, 0, 3, mdl[3], "x3_after_rst");
        rd(0, 1, 20, mdl[20], "x20_after_rst");
        drain();
        chk("busy_idle_after_rst", {31'b0, busy_a}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
